// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_arb_pkg;

    // Arbitration FSM states
    typedef enum logic [1:0] {
        SHARE = 2'd0,
        FORCE = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    // Owner encoding carried by the read-response pipe
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // Saturating increment for the 4-bit starvation counter
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_rsp_router.sv
// Read-response router: remembers who owns the load issued last cycle and
// steers the memory's read data to that requester's rvalid/rdata.
module dmem_rsp_router
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_gnt_i,
    input  logic              ld_who_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic              own_vld_q, own_vld_d;
    logic              own_who_q, own_who_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    // The response is valid in the cycle after the granted load
    assign cpu_rvalid_o = own_vld_q & (own_who_q == OWN_CPU);
    assign dbg_rvalid_o = own_vld_q & (own_who_q == OWN_DBG);
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
    assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : dbg_rdata_q;

    // Next owner entry and hold values for each requester's read data
    always_comb begin
        own_vld_d   = ld_gnt_i;
        own_who_d   = own_who_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        if (ld_gnt_i) begin
            own_who_d = ld_who_i;
        end else begin
            own_who_d = own_who_q;
        end
        if (cpu_rvalid_o) begin
            cpu_rdata_d = mem_rdata_i;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
        if (dbg_rvalid_o) begin
            dbg_rdata_d = mem_rdata_i;
        end else begin
            dbg_rdata_d = dbg_rdata_q;
        end
    end

    // Owner pipe and held read data; reset drops any pending response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_vld_q   <= 1'b0;
            own_who_q   <= OWN_CPU;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            own_vld_q   <= own_vld_d;
            own_who_q   <= own_who_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU MEM stage has
// priority, a starvation counter forces debug progress, debug may lock.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_locked,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Denial count at which the next denial hands the port to debug
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    arb_state_e state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       locked_q;
    logic       cpu_gnt_s, dbg_gnt_s;

    // Grants are suppressed while reset is high
    assign cpu_gnt   = cpu_gnt_s & ~reset;
    assign dbg_gnt   = dbg_gnt_s & ~reset;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign dbg_locked = locked_q;

    assign mem_en    = cpu_gnt | dbg_gnt;
    assign mem_we    = cpu_gnt ? cpu_we    : (dbg_gnt & dbg_we);
    assign mem_addr  = cpu_gnt ? cpu_addr  : dbg_addr;
    assign mem_wdata = cpu_gnt ? cpu_wdata : dbg_wdata;

    // Grant decision, next state and starvation counter
    always_comb begin
        cpu_gnt_s  = 1'b0;
        dbg_gnt_s  = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            SHARE: begin
                cpu_gnt_s = cpu_req;
                dbg_gnt_s = dbg_req & ~cpu_req;
                if (dbg_req & cpu_req) begin
                    wait_cnt_d = sat_inc4(wait_cnt_q);
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = FORCE;
                    end else begin
                        state_d = SHARE;
                    end
                end else begin
                    wait_cnt_d = 4'd0;
                    if (dbg_lock & dbg_gnt_s) begin
                        state_d = LOCK;
                    end else begin
                        state_d = SHARE;
                    end
                end
            end
            FORCE: begin
                dbg_gnt_s  = dbg_req;
                wait_cnt_d = 4'd0;
                state_d    = SHARE;
            end
            LOCK: begin
                dbg_gnt_s  = dbg_req;
                wait_cnt_d = 4'd0;
                if (dbg_lock) begin
                    state_d = LOCK;
                end else begin
                    state_d = SHARE;
                end
            end
            default: begin
                wait_cnt_d = 4'd0;
                state_d    = SHARE;
            end
        endcase
    end

    // State, counter and lock-status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SHARE;
            wait_cnt_q <= 4'd0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            locked_q   <= (state_d == LOCK);
        end
    end

    dmem_rsp_router #(
        .DATA_W(DATA_W)
    ) u_rsp_router (
        .clk         (clk),
        .reset       (reset),
        .ld_gnt_i    ((cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we)),
        .ld_who_i    (dbg_gnt ? OWN_DBG : OWN_CPU),
        .mem_rdata_i (mem_rdata),
        .cpu_rvalid_o(cpu_rvalid),
        .cpu_rdata_o (cpu_rdata),
        .dbg_rvalid_o(dbg_rvalid),
        .dbg_rdata_o (dbg_rdata)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural
// single-port memory (1-cycle read latency).
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt, dbg_locked, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_locked(dbg_locked),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural data memory: write-through on store, registered read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'd0; cpu_wdata = 32'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'd0; dbg_wdata = 32'd0;
        dbg_lock = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mem_rdata = 32'd0;
        clear_inputs();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[5] = 32'd42;
        mem[3] = 32'd33;

        // Reset state: requests present but nothing granted
        cpu_req = 1'b1; dbg_req = 1'b1;
        #3;
        check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check_eq("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
        check_eq("rst_locked", 32'(dbg_locked), 32'd0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();

        // Idle: no requests
        #1;
        check_eq("idle_mem_en", 32'(mem_en), 32'd0);
        check_eq("idle_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
        check_eq("idle_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
        tick();
        #1;
        check_eq("idle_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);

        // CPU-only load of d_mem[5]=42
        cpu_req = 1'b1; cpu_addr = 8'd5;
        #1;
        check_eq("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check_eq("t1_cpu_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_req = 1'b0;
        #1;
        check_eq("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check_eq("t1_cpu_rdata", cpu_rdata, 32'd42);
        check_eq("t1_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        tick();

        // Starvation: CPU held high, debug LD addr 3 forced through on cycle 4
        cpu_req = 1'b1; cpu_addr = 8'd6;
        dbg_req = 1'b1; dbg_addr = 8'd3;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("t2_dbg_denied_c%0d", c), 32'({dbg_gnt, cpu_gnt, cpu_stall}), 32'b010);
            tick();
        end
        #1;
        check_eq("t2_dbg_forced", 32'({dbg_gnt, cpu_gnt, cpu_stall}), 32'b101);
        tick();
        dbg_req = 1'b0;
        #1;
        check_eq("t2_cpu_back", 32'({cpu_gnt, cpu_stall}), 32'b10);
        check_eq("t2_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        check_eq("t2_dbg_rdata", dbg_rdata, 32'd33);
        check_eq("t2_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        clear_inputs();
        tick();

        // Lock burst: debug stores 7,8,9 to addr 0..2 while holding the lock
        dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd0; dbg_wdata = 32'd7;
        #1;
        check_eq("t3_lock_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        cpu_req = 1'b1; cpu_addr = 8'd5;
        for (int k = 1; k < 3; k++) begin
            dbg_addr = 8'(k); dbg_wdata = 32'(7 + k);
            #1;
            check_eq($sformatf("t3_burst_%0d", k), 32'({dbg_gnt, cpu_gnt, cpu_stall, dbg_locked}), 32'b1011);
            tick();
        end
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
        #1;
        check_eq("t3_release_cycle", 32'({cpu_gnt, cpu_stall, dbg_locked}), 32'b011);
        tick();
        #1;
        check_eq("t3_cpu_after", 32'({cpu_gnt, cpu_stall, dbg_locked}), 32'b100);
        tick();
        clear_inputs();
        check_eq("t3_mem0", mem[0], 32'd7);
        check_eq("t3_mem1", mem[1], 32'd8);
        check_eq("t3_mem2", mem[2], 32'd9);
        tick();

        // Alternating: CPU ST addr 9 = 0x55, then debug LD addr 9
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd9; cpu_wdata = 32'h55;
        #1;
        check_eq("t4_cpu_st_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
        dbg_req = 1'b1; dbg_addr = 8'd9;
        #1;
        check_eq("t4_dbg_ld_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        dbg_req = 1'b0;
        #1;
        check_eq("t4_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        check_eq("t4_dbg_rdata", dbg_rdata, 32'h55);
        check_eq("t4_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();

        // Back-to-back loads to alternating requesters, responses in order
        cpu_req = 1'b1; cpu_addr = 8'd5;
        #1;
        check_eq("t4b_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_addr = 8'd1;
        #1;
        check_eq("t4b_cycle1", 32'({dbg_gnt, cpu_rvalid, dbg_rvalid}), 32'b110);
        check_eq("t4b_cpu_rdata", cpu_rdata, 32'd42);
        tick();
        dbg_req = 1'b0;
        #1;
        check_eq("t4b_cycle2", 32'({cpu_rvalid, dbg_rvalid}), 32'b01);
        check_eq("t4b_dbg_rdata", dbg_rdata, 32'd8);
        tick();

        // Reset in the cycle after a granted CPU load drops the response
        cpu_req = 1'b1; cpu_addr = 8'd3;
        #1;
        check_eq("t5_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check_eq("t5_rvalid_dropped", 32'(cpu_rvalid), 32'd0);
        check_eq("t5_gnt_forced0", 32'({cpu_gnt, dbg_gnt, mem_en}), 32'd0);
        tick();
        reset = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_eq("t5_state_share", 32'(dut.state_q), 32'(SHARE));
        check_eq("t5_rvalid_after", 32'(cpu_rvalid), 32'd0);
        cpu_req = 1'b1; dbg_req = 1'b1; dbg_addr = 8'd4;
        #1;
        check_eq("t5_share_prio", 32'({cpu_gnt, dbg_gnt}), 32'b10);
        tick();
        clear_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
